button_debouncer: RTL and testbench

- Board push-button input conditioner: the input-side counterpart of the seven-segment display driver.
- Synchronises raw active-high button pins (Nexys BTNC/U/L/R/D) into the clk_peripheral domain and debounces them on a slow sample tick.
- Emits debounced level plus single-cycle press, release and auto-repeat strobes for the monitor/control logic, e.g. stepping cpu_speed or the displayed address.

---
 rtl/button_debouncer.sv | 105 ++++++++++
 tb/tb_button_debouncer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_debouncer                                                           |
// | Synchronises and debounces push-buttons; emits level, press, release and   |
// | auto-repeat strobes.                                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module button_debouncer #(
  parameter int N            = 5,
  parameter int DIV          = 12,
  parameter int DEBOUNCE     = 8,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 25
) (
  input  logic         clk_peripheral,
  input  logic         reset_n,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat,
  output logic         any_press
);

  localparam logic [7:0] c_deb_last  = 8'(DEBOUNCE - 1);
  localparam logic [7:0] c_rep_delay = 8'(REPEAT_DELAY);
  localparam logic [7:0] c_rep_rate  = 8'(REPEAT_RATE);

  logic [N-1:0]   r_sync1;
  logic [N-1:0]   r_sync2;
  logic [N-1:0]   r_state;
  logic [N-1:0]   r_press;
  logic [N-1:0]   r_release;
  logic [N-1:0]   r_repeat;
  logic           r_any;
  logic [DIV-1:0] r_div;
  logic [7:0]     r_cnt  [N];
  logic [7:0]     r_rcnt [N];

  logic           w_tick;
  logic [N-1:0]   w_diff;
  logic [N-1:0]   w_commit;

  always_comb begin
    w_tick   = &r_div;
    w_diff   = r_sync2 ^ r_state;
    w_commit = '0;
    for (int i = 0; i < N; i++) begin
      w_commit[i] = w_tick && w_diff[i] && (r_cnt[i] == c_deb_last);
    end
  end

  always_ff @(posedge clk_peripheral or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      r_any     <= 1'b0;
      r_div     <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i]  <= '0;
        r_rcnt[i] <= '0;
      end
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_div     <= r_div + DIV'(1);
      r_state   <= r_state ^ w_commit;
      r_press   <= w_commit & r_sync2;
      r_release <= w_commit & ~r_sync2;
      r_any     <= |(w_commit & r_sync2);
      r_repeat  <= '0;
      for (int i = 0; i < N; i++) begin
        if (w_tick) begin
          if (w_commit[i]) begin
            r_cnt[i]  <= '0;
            r_rcnt[i] <= r_sync2[i] ? c_rep_delay : 8'd0;
          end else begin
            // any tick where sync agrees with state restarts qualification
            r_cnt[i] <= w_diff[i] ? r_cnt[i] + 8'd1 : 8'd0;
            if (r_state[i]) begin
              if (r_rcnt[i] == 8'd1) begin
                r_repeat[i] <= 1'b1;
                r_rcnt[i]   <= c_rep_rate;
              end else if (r_rcnt[i] != 8'd0) begin
                r_rcnt[i] <= r_rcnt[i] - 8'd1;
              end
            end
          end
        end
      end
    end
  end

  assign btn_state   = r_state;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_repeat  = r_repeat;
  assign any_press   = r_any;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_button_debouncer                                                        |
// | Directed self-checking bench for button_debouncer (DIV=2, DEBOUNCE=3).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_button_debouncer;

  logic       clk_peripheral = 1'b0;
  logic       reset_n        = 1'b0;
  logic [4:0] btn_raw        = 5'h1F;
  logic [4:0] btn_state;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_repeat;
  logic       any_press;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  button_debouncer #(
    .N(5), .DIV(2), .DEBOUNCE(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk_peripheral (clk_peripheral),
    .reset_n        (reset_n),
    .btn_raw        (btn_raw),
    .btn_state      (btn_state),
    .btn_press      (btn_press),
    .btn_release    (btn_release),
    .btn_repeat     (btn_repeat),
    .any_press      (any_press)
  );

  always #5 clk_peripheral = ~clk_peripheral;

  // edges since reset release; a tick lands on every edge where cyc % 4 == 0
  always @(posedge clk_peripheral) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"},   8'(btn_state),   8'h00);
    check({tag, "_press"},   8'(btn_press),   8'h00);
    check({tag, "_release"}, 8'(btn_release), 8'h00);
    check({tag, "_repeat"},  8'(btn_repeat),  8'h00);
    check({tag, "_any"},     8'(any_press),   8'h00);
  endtask

  // advance to the next tick edge, check outputs there, then check strobes drop
  task automatic tk(input string tag, input logic [4:0] st, input logic [4:0] pr,
                    input logic [4:0] rl, input logic [4:0] rp);
    do begin
      @(posedge clk_peripheral); #1;
    end while (cyc % 4 != 0);
    check({tag, "_state"},   8'(btn_state),   8'(st));
    check({tag, "_press"},   8'(btn_press),   8'(pr));
    check({tag, "_release"}, 8'(btn_release), 8'(rl));
    check({tag, "_repeat"},  8'(btn_repeat),  8'(rp));
    check({tag, "_any"},     8'(any_press),   8'(|pr));
    @(posedge clk_peripheral); #1;
    check({tag, "_st_next"},  8'(btn_state),   8'(st));
    check({tag, "_pr_next"},  8'(btn_press),   8'h00);
    check({tag, "_rl_next"},  8'(btn_release), 8'h00);
    check({tag, "_rp_next"},  8'(btn_repeat),  8'h00);
    check({tag, "_any_next"}, 8'(any_press),   8'h00);
  endtask

  initial begin
    // 1: all buttons held through reset
    repeat (3) @(posedge clk_peripheral);
    #1;
    check_zero("t1_in_reset");
    @(negedge clk_peripheral) reset_n = 1'b1;
    @(posedge clk_peripheral); #1;
    check_zero("t1_first_edge");
    tk("t1_q1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t1_q2", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t1_press", 5'h1F, 5'h1F, 5'h00, 5'h00);
    btn_raw = 5'h00;
    tk("t1_r1", 5'h1F, 5'h00, 5'h00, 5'h00);
    tk("t1_r2", 5'h1F, 5'h00, 5'h00, 5'h00);
    tk("t1_rel", 5'h00, 5'h00, 5'h1F, 5'h00);

    // 2: clean press and release on bit 0
    btn_raw = 5'h01;
    tk("t2_q1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t2_q2", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t2_press", 5'h01, 5'h01, 5'h00, 5'h00);
    btn_raw = 5'h00;
    tk("t2_r1", 5'h01, 5'h00, 5'h00, 5'h00);
    tk("t2_r2", 5'h01, 5'h00, 5'h00, 5'h00);
    tk("t2_rel", 5'h00, 5'h00, 5'h01, 5'h00);

    // 3: bounce on bit 2
    btn_raw = 5'h04;
    tk("t3_b1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t3_b2", 5'h00, 5'h00, 5'h00, 5'h00);
    btn_raw = 5'h00;
    tk("t3_low", 5'h00, 5'h00, 5'h00, 5'h00);
    btn_raw = 5'h04;
    tk("t3_b3", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t3_b4", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t3_press", 5'h04, 5'h04, 5'h00, 5'h00);
    btn_raw = 5'h00;
    tk("t3_r1", 5'h04, 5'h00, 5'h00, 5'h00);
    tk("t3_r2", 5'h04, 5'h00, 5'h00, 5'h00);
    tk("t3_rel", 5'h00, 5'h00, 5'h04, 5'h00);

    // 4: hold bit 1, repeats at press+4,+6,...,+14 ticks
    btn_raw = 5'h02;
    tk("t4_q1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t4_q2", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t4_press", 5'h02, 5'h02, 5'h00, 5'h00);
    for (int k = 1; k <= 12; k++) begin
      tk($sformatf("t4_hold%0d", k), 5'h02, 5'h00, 5'h00,
         (k >= 4 && k % 2 == 0) ? 5'h02 : 5'h00);
    end
    btn_raw = 5'h00;
    tk("t4_hold13", 5'h02, 5'h00, 5'h00, 5'h00);
    tk("t4_hold14", 5'h02, 5'h00, 5'h00, 5'h02);
    tk("t4_rel", 5'h00, 5'h00, 5'h02, 5'h00);
    tk("t4_after1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t4_after2", 5'h00, 5'h00, 5'h00, 5'h00);

    // 5: bits 3 and 4 together
    btn_raw = 5'h18;
    tk("t5_q1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t5_q2", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t5_press", 5'h18, 5'h18, 5'h00, 5'h00);
    btn_raw = 5'h00;
    tk("t5_r1", 5'h18, 5'h00, 5'h00, 5'h00);
    tk("t5_r2", 5'h18, 5'h00, 5'h00, 5'h00);
    tk("t5_rel", 5'h00, 5'h00, 5'h18, 5'h00);

    // 6: reset pulse while bit 0 is mid-qualification
    btn_raw = 5'h01;
    tk("t6_q1", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t6_q2", 5'h00, 5'h00, 5'h00, 5'h00);
    @(negedge clk_peripheral) reset_n = 1'b0;
    #1;
    check_zero("t6_in_reset");
    @(negedge clk_peripheral) reset_n = 1'b1;
    tk("t6_q1b", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t6_q2b", 5'h00, 5'h00, 5'h00, 5'h00);
    tk("t6_press", 5'h01, 5'h01, 5'h00, 5'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
